data_cache_ctrl: RTL and testbench
==================================

# data_cache_ctrl

Direct-mapped, write-back data-cache controller that generalises the single-window data-cache hit logic to `LINE_NUM` independently tagged lines of `LINE_DEPTH` words each. It sits between the AP controller's data load/store path and the DDR burst interface. It performs the tag lookup, dirty-line write-back, refill bursts and cache-array addressing. On completion it returns a cache-array word address.

## Interface
- `LINE_NUM`, 4: number of cache lines; power of two, ≥2.
- `LINE_DEPTH`, 16: words per line; power of two.
- `DATA_WIDTH`, 16: word width.
- `ADDR_WIDTH_MEM`, 16: word-address width.
- `DDR_ADDR_WIDTH`, 28: DDR byte-address width.
- `DDR_SHIFT`, 3: left shift from word address to DDR address.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH_MEM  word address.
- req_we  in  1  access is a write; marks line dirty.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  access hit without refill.
- resp_cache_addr  out  clog2(LINE_NUM*LINE_DEPTH)  cache-array word index.
- rd_burst_req  out  1  DDR read request, held until finish.
- rd_burst_addr  out  DDR_ADDR_WIDTH  refill base address.
- rd_burst_len  out  10  equals LINE_DEPTH.
- rd_burst_data_valid  in  1  refill beat.
- rd_burst_data  in  DATA_WIDTH  refill data.
- rd_burst_finish  in  1  read burst complete.
- wr_burst_req  out  1  DDR write request, held until finish.
- wr_burst_addr  out  DDR_ADDR_WIDTH  write-back base address.
- wr_burst_len  out  10  equals LINE_DEPTH.
- wr_burst_data_req  in  1  DDR requests the next write-back beat.
- wr_burst_finish  in  1  write burst complete.
- ca_wr_en / ca_wr_addr / ca_wr_data  out  1 / idx / DATA_WIDTH  cache-array refill write port.
- ca_rd_en / ca_rd_addr  out  1 / idx  cache-array write-back read port.
- err_overflow  out  1  sticky: a beat arrived beyond LINE_DEPTH.

## Operation
- Address split: `offset = addr[OW-1:0]`, `index = addr[OW+IW-1:OW]`, `tag = upper bits`.
  - `OW = clog2(LINE_DEPTH)`, `IW = clog2(LINE_NUM)`.
- Per-line state: valid bit, dirty bit, tag.
- FSM states: IDLE, LOOKUP, WB, RF, DONE.
- IDLE: on `req_valid` (with `req_ready` = 1), register the address and we flag, then go to LOOKUP.
- LOOKUP: compare against the registered tag state.
  - Hit: if we, set dirty; assert `resp_valid` and `resp_hit` = 1; return to IDLE.
  - Miss with victim valid and dirty: go to WB.
  - Miss otherwise: go to RF.
- WB:
  - `wr_burst_addr = {victim_tag, index, OW'b0} << DDR_SHIFT`, zero-extended or truncated to DDR_ADDR_WIDTH.
  - Each `wr_burst_data_req` issues `ca_rd_en` with `ca_rd_addr = index*LINE_DEPTH + cnt`, then increments cnt.
  - On `wr_burst_finish`, clear dirty and go to RF.
- RF:
  - `rd_burst_addr` = new line base << DDR_SHIFT.
  - Each `rd_burst_data_valid` with cnt < LINE_DEPTH writes `ca_wr_*` at `index*LINE_DEPTH + cnt`.
  - Beats at cnt ≥ LINE_DEPTH are dropped and set `err_overflow`.
  - On `rd_burst_finish`: set valid, load the tag, set dirty = we, go to DONE.
- DONE: `resp_valid` = 1, `resp_hit` = 0; return to IDLE.
- `resp_cache_addr = index*LINE_DEPTH + offset`, held stable from the response until the next acceptance.
- The write policy is write-allocate.
- A data beat and finish in the same cycle: the beat is processed, then the state transitions.
- A request while not in IDLE is not accepted; the requester holds it.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE, so `req_ready` = 1.
  - All valid/dirty bits and counters 0; `err_overflow` 0.
- Hit latency: `resp_valid` is asserted exactly 1 cycle after the acceptance cycle.
- Miss latency: 1 + WB duration + RF duration + 1 cycles.
- Burst request outputs are asserted the cycle after entering WB/RF.
- `rd_burst_req` deasserts the cycle after `rd_burst_finish`; `wr_burst_req` deasserts the cycle after `wr_burst_finish`.
- Reset mid-burst: the FSM aborts to IDLE and all lines are invalidated. The DDR controller must be reset concurrently.

## Configuration
- `DC_STATS_EN` defined: adds outputs `hit_cnt` and `miss_cnt`.
  - Both 16 bits, saturating at 0xFFFF, reset 0.
  - Each increments on the `resp_valid` cycle according to `resp_hit`.
- `DC_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `dc_pkg` holds:
  - FSM state enum.
  - `BURST_LEN_W` = 10.
  - Width helper constants (OW, IW, tag width).
- Sub-module `dc_tag_store`: valid/dirty/tag arrays with one lookup port and one update port; reset clears valid and dirty.

## Test plan
Configuration for all scenarios: LINE_NUM = 4, LINE_DEPTH = 16, DDR_SHIFT = 3.
1. Cold read of 0x0023 → miss, no WB, `rd_burst_addr` = 0x100, len 16; 16 writes to `ca_wr_addr` 32..47; `resp_cache_addr` = 35, `resp_hit` = 0.
2. Then read 0x002A → `resp_valid` 1 cycle after accept, `resp_hit` = 1, `resp_cache_addr` = 42, no burst requests.
3. Write 0x0025 (hit, dirty), then read 0x0065 → WB at 0x100 with `ca_rd_addr` 32..47, then RF at 0x300, `resp_cache_addr` = 37.
4. Refill delivering 18 beats before finish → exactly 16 `ca_wr_en` pulses, `err_overflow` = 1 and sticky.
5. Assert rst at the 5th beat of a refill of 0x0023 → all outputs 0, `req_ready` = 1; re-reading 0x0023 misses again.
6. With `DC_STATS_EN`: scenarios 1–3 → `hit_cnt` = 2, `miss_cnt` = 2.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared types and width helpers for the direct-mapped data-cache controller.
package dc_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_RF     = 3'd3,
        ST_DONE   = 3'd4
    } dc_state_t;

    // DDR burst length field width
    localparam int BURST_LEN_W = 10;

    // Hit/miss statistics counter width
    localparam int STATS_W = 16;

    // Offset-within-line width
    function automatic int dc_offset_w(input int line_depth);
        return $clog2(line_depth);
    endfunction

    // Line-index width
    function automatic int dc_index_w(input int line_num);
        return $clog2(line_num);
    endfunction

    // Tag width: whatever remains of the word address above index and offset
    function automatic int dc_tag_w(input int addr_w, input int line_num, input int line_depth);
        return addr_w - $clog2(line_num) - $clog2(line_depth);
    endfunction

endpackage

// File: rtl/dc_tag_store.sv
// Per-line valid/dirty/tag state. One combinational lookup port reading the
// registered arrays, one synchronous update port. Reset clears every line.
module dc_tag_store #(
    parameter int LINE_NUM = 4,
    parameter int IW       = 2,
    parameter int TAG_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    lk_index,
    output logic             lk_valid,
    output logic             lk_dirty,
    output logic [TAG_W-1:0] lk_tag,
    input  logic             up_en,
    input  logic [IW-1:0]    up_index,
    input  logic             up_valid,
    input  logic             up_dirty,
    input  logic [TAG_W-1:0] up_tag
);

    logic             valid_reg [LINE_NUM];
    logic             dirty_reg [LINE_NUM];
    logic [TAG_W-1:0] tag_reg   [LINE_NUM];

    generate
        for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_line
            // Each line updates only when the update port addresses it
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                    dirty_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= '0;
                end else if (up_en && (up_index == IW'(gi))) begin
                    valid_reg[gi] <= up_valid;
                    dirty_reg[gi] <= up_dirty;
                    tag_reg[gi]   <= up_tag;
                end
            end
        end
    endgenerate

    assign lk_valid = valid_reg[lk_index];
    assign lk_dirty = dirty_reg[lk_index];
    assign lk_tag   = tag_reg[lk_index];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data-cache controller: tag lookup,
// dirty-line write-back burst, refill burst and cache-array addressing.
// Optional build macro DC_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module data_cache_ctrl
    import dc_pkg::*;
#(
    parameter int LINE_NUM       = 4,
    parameter int LINE_DEPTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_SHIFT      = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [ADDR_WIDTH_MEM-1:0]              req_addr,
    input  logic                                   req_we,
    output logic                                   resp_valid,
    output logic                                   resp_hit,
    output logic [$clog2(LINE_NUM*LINE_DEPTH)-1:0] resp_cache_addr,
    output logic                                   rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]              rd_burst_addr,
    output logic [BURST_LEN_W-1:0]                 rd_burst_len,
    input  logic                                   rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]                  rd_burst_data,
    input  logic                                   rd_burst_finish,
    output logic                                   wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]              wr_burst_addr,
    output logic [BURST_LEN_W-1:0]                 wr_burst_len,
    input  logic                                   wr_burst_data_req,
    input  logic                                   wr_burst_finish,
    output logic                                   ca_wr_en,
    output logic [$clog2(LINE_NUM*LINE_DEPTH)-1:0] ca_wr_addr,
    output logic [DATA_WIDTH-1:0]                  ca_wr_data,
    output logic                                   ca_rd_en,
    output logic [$clog2(LINE_NUM*LINE_DEPTH)-1:0] ca_rd_addr,
    output logic                                   err_overflow
`ifdef DC_STATS_EN
    ,
    output logic [STATS_W-1:0]                     hit_cnt,
    output logic [STATS_W-1:0]                     miss_cnt
`endif
);

    localparam int OW    = dc_offset_w(LINE_DEPTH);
    localparam int IW    = dc_index_w(LINE_NUM);
    localparam int TAG_W = dc_tag_w(ADDR_WIDTH_MEM, LINE_NUM, LINE_DEPTH);
    localparam int IDX_W = OW + IW;
    localparam int CNT_W = OW + 1;
    localparam int EXT_W = ADDR_WIDTH_MEM + DDR_SHIFT;

    dc_state_t                 state_reg, state_next;
    logic [ADDR_WIDTH_MEM-1:0] addr_reg;
    logic                      we_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      rd_req_reg, wr_req_reg;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_reg, wr_addr_reg;
    logic                      ca_wr_en_reg, ca_rd_en_reg;
    logic [IDX_W-1:0]          ca_wr_addr_reg, ca_rd_addr_reg;
    logic [DATA_WIDTH-1:0]     ca_wr_data_reg;
    logic                      err_reg;

    logic [IW-1:0]             req_index;
    logic [TAG_W-1:0]          req_tag;
    logic                      lk_valid, lk_dirty, hit;
    logic [TAG_W-1:0]          lk_tag;
    logic                      up_en, up_valid, up_dirty;
    logic [TAG_W-1:0]          up_tag;
    logic                      cnt_in_line;
    logic [EXT_W-1:0]          new_ext, victim_ext;

    assign req_index   = addr_reg[IDX_W-1:OW];
    assign req_tag     = addr_reg[ADDR_WIDTH_MEM-1:IDX_W];
    assign hit         = lk_valid && (lk_tag == req_tag);
    assign cnt_in_line = (cnt_reg < CNT_W'(LINE_DEPTH));

    // DDR base addresses of the requested line and of the resident victim
    assign new_ext    = EXT_W'({req_tag, req_index, {OW{1'b0}}}) << DDR_SHIFT;
    assign victim_ext = EXT_W'({lk_tag, req_index, {OW{1'b0}}}) << DDR_SHIFT;

    dc_tag_store #(
        .LINE_NUM (LINE_NUM),
        .IW       (IW),
        .TAG_W    (TAG_W)
    ) u_tag_store (
        .clk      (clk),
        .rst      (rst),
        .lk_index (req_index),
        .lk_valid (lk_valid),
        .lk_dirty (lk_dirty),
        .lk_tag   (lk_tag),
        .up_en    (up_en),
        .up_index (req_index),
        .up_valid (up_valid),
        .up_dirty (up_dirty),
        .up_tag   (up_tag)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next state, response strobes and tag-store updates
    always_comb begin
        state_next = state_reg;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        up_en      = 1'b0;
        up_valid   = 1'b0;
        up_dirty   = 1'b0;
        up_tag     = lk_tag;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    up_en      = we_reg;
                    up_valid   = 1'b1;
                    up_dirty   = 1'b1;
                    state_next = ST_IDLE;
                end else if (lk_valid && lk_dirty) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_RF;
                end
            end
            ST_WB: begin
                if (wr_burst_finish) begin
                    up_en      = 1'b1;
                    up_valid   = lk_valid;
                    up_dirty   = 1'b0;
                    state_next = ST_RF;
                end
            end
            ST_RF: begin
                if (rd_burst_finish) begin
                    up_en      = 1'b1;
                    up_valid   = 1'b1;
                    up_dirty   = we_reg;
                    up_tag     = req_tag;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, beat counter, burst handshakes and cache-array ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            cnt_reg        <= '0;
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            rd_addr_reg    <= '0;
            wr_addr_reg    <= '0;
            ca_wr_en_reg   <= 1'b0;
            ca_wr_addr_reg <= '0;
            ca_wr_data_reg <= '0;
            ca_rd_en_reg   <= 1'b0;
            ca_rd_addr_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            ca_wr_en_reg <= 1'b0;
            ca_rd_en_reg <= 1'b0;
            rd_req_reg   <= (state_reg == ST_RF) && !rd_burst_finish;
            wr_req_reg   <= (state_reg == ST_WB) && !wr_burst_finish;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_reg <= req_addr;
                        we_reg   <= req_we;
                    end
                end
                ST_LOOKUP: begin
                    cnt_reg <= '0;
                    if (!hit) begin
                        rd_addr_reg <= DDR_ADDR_WIDTH'(new_ext);
                        wr_addr_reg <= DDR_ADDR_WIDTH'(victim_ext);
                    end
                end
                ST_WB: begin
                    if (wr_burst_data_req && cnt_in_line) begin
                        ca_rd_en_reg   <= 1'b1;
                        ca_rd_addr_reg <= {req_index, cnt_reg[OW-1:0]};
                    end
                    // A finish in the same cycle as the last request still
                    // issues that read; the counter restarts for the refill
                    if (wr_burst_finish)
                        cnt_reg <= '0;
                    else if (wr_burst_data_req && cnt_in_line)
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_RF: begin
                    if (rd_burst_data_valid) begin
                        if (cnt_in_line) begin
                            ca_wr_en_reg   <= 1'b1;
                            ca_wr_addr_reg <= {req_index, cnt_reg[OW-1:0]};
                            ca_wr_data_reg <= rd_burst_data;
                            cnt_reg        <= cnt_reg + CNT_W'(1);
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready       = (state_reg == ST_IDLE);
    assign resp_cache_addr = addr_reg[IDX_W-1:0];
    assign rd_burst_req    = rd_req_reg;
    assign rd_burst_addr   = rd_addr_reg;
    assign rd_burst_len    = rd_req_reg ? BURST_LEN_W'(LINE_DEPTH) : '0;
    assign wr_burst_req    = wr_req_reg;
    assign wr_burst_addr   = wr_addr_reg;
    assign wr_burst_len    = wr_req_reg ? BURST_LEN_W'(LINE_DEPTH) : '0;
    assign ca_wr_en        = ca_wr_en_reg;
    assign ca_wr_addr      = ca_wr_addr_reg;
    assign ca_wr_data      = ca_wr_data_reg;
    assign ca_rd_en        = ca_rd_en_reg;
    assign ca_rd_addr      = ca_rd_addr_reg;
    assign err_overflow    = err_reg;

`ifdef DC_STATS_EN
    logic [STATS_W-1:0] hit_cnt_reg, miss_cnt_reg;

    // Saturating hit/miss counters, stepped on each completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (resp_valid) begin
            if (resp_hit && (hit_cnt_reg != '1))
                hit_cnt_reg <= hit_cnt_reg + STATS_W'(1);
            if (!resp_hit && (miss_cnt_reg != '1))
                miss_cnt_reg <= miss_cnt_reg + STATS_W'(1);
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl (LINE_NUM=4, LINE_DEPTH=16, DDR_SHIFT=3).
// Acts as the DDR controller inline and logs cache-array port activity.
// Build with DC_STATS_EN defined to also check the hit/miss counters.
module tb_data_cache_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic        resp_valid, resp_hit;
    logic [5:0]  resp_cache_addr;
    logic        rd_burst_req;
    logic [27:0] rd_burst_addr;
    logic [9:0]  rd_burst_len;
    logic        rd_burst_data_valid = 1'b0;
    logic [15:0] rd_burst_data = '0;
    logic        rd_burst_finish = 1'b0;
    logic        wr_burst_req;
    logic [27:0] wr_burst_addr;
    logic [9:0]  wr_burst_len;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;
    logic        ca_wr_en;
    logic [5:0]  ca_wr_addr;
    logic [15:0] ca_wr_data;
    logic        ca_rd_en;
    logic [5:0]  ca_rd_addr;
    logic        err_overflow;
`ifdef DC_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    data_cache_ctrl #(
        .LINE_NUM       (4),
        .LINE_DEPTH     (16),
        .DATA_WIDTH     (16),
        .ADDR_WIDTH_MEM (16),
        .DDR_ADDR_WIDTH (28),
        .DDR_SHIFT      (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_we              (req_we),
        .resp_valid          (resp_valid),
        .resp_hit            (resp_hit),
        .resp_cache_addr     (resp_cache_addr),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .ca_wr_en            (ca_wr_en),
        .ca_wr_addr          (ca_wr_addr),
        .ca_wr_data          (ca_wr_data),
        .ca_rd_en            (ca_rd_en),
        .ca_rd_addr          (ca_rd_addr),
        .err_overflow        (err_overflow)
`ifdef DC_STATS_EN
        ,
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;

    // Cache-array port logs, sampled 2 time units after each rising edge
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [5:0]  wr_log  [256];
    logic [15:0] wr_dlog [256];
    logic [5:0]  rd_log  [256];

    always @(posedge clk) begin
        #2;
        if (ca_wr_en) begin
            if (wr_pulses < 256) begin
                wr_log[wr_pulses]  = ca_wr_addr;
                wr_dlog[wr_pulses] = ca_wr_data;
            end
            wr_pulses++;
        end
        if (ca_rd_en) begin
            if (rd_pulses < 256) rd_log[rd_pulses] = ca_rd_addr;
            rd_pulses++;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations from the most recent access
    logic        wb_seen, rf_seen, wr_drop, rd_drop;
    logic [27:0] wb_addr, rf_addr;
    logic [9:0]  wb_len, rf_len;

    // One cache access, with this task playing the DDR side. rst_beat >= 0
    // asserts reset instead of delivering that refill beat.
    task automatic run_access(input logic [15:0] addr, input logic we, input int nbeats,
                              input int rst_beat, output logic hit, output int lat,
                              output logic [5:0] caddr, output logic aborted);
        int   cyc;
        logic done;
        wb_seen = 0; rf_seen = 0; wr_drop = 0; rd_drop = 0;
        wb_addr = '0; rf_addr = '0; wb_len = '0; rf_len = '0;
        hit = 0; lat = 0; caddr = '0; aborted = 0; done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_we = we;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            if (resp_valid) begin
                hit = resp_hit; lat = cyc; caddr = resp_cache_addr; done = 1;
            end else if (wr_burst_req) begin
                wb_seen = 1; wb_addr = wr_burst_addr; wb_len = wr_burst_len;
                for (int i = 0; i < DEPTH; i++) begin
                    wr_burst_data_req = 1'b1;
                    wr_burst_finish   = (i == DEPTH - 1);
                    @(negedge clk); cyc++;
                end
                wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
                wr_drop = wr_burst_req;
            end else if (rd_burst_req) begin
                rf_seen = 1; rf_addr = rd_burst_addr; rf_len = rd_burst_len;
                for (int i = 0; i < nbeats && !aborted; i++) begin
                    if (i == rst_beat) begin
                        rst = 1'b0; aborted = 1;
                    end else begin
                        rd_burst_data_valid = 1'b1;
                        rd_burst_data       = 16'h1000 + 16'(i);
                        rd_burst_finish     = (i == nbeats - 1);
                        @(negedge clk); cyc++;
                    end
                end
                rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
                if (aborted) done = 1;
                else rd_drop = rd_burst_req;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        check_vec($sformatf("resp_in_time_%04h", addr), 32'(done), 32'd1);
        $display("access addr=0x%04h we=%0d -> hit=%0d lat=%0d cache_addr=%0d wb=%0d rf=%0d reset=%0d",
                 addr, we, hit, lat, caddr, wb_seen, rf_seen, aborted);
    endtask

    logic       hit, ab;
    int         lat, wb0, rb0;
    logic [5:0] caddr;

    initial begin
        // Reset state (asynchronous reset is already asserted)
        #1;
        check_vec("rst_req_ready", 32'(req_ready), 32'd1);
        check_vec("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_vec("rst_rd_req", 32'(rd_burst_req), 32'd0);
        check_vec("rst_wr_req", 32'(wr_burst_req), 32'd0);
        check_vec("rst_ca_wr_en", 32'(ca_wr_en), 32'd0);
        check_vec("rst_err", 32'(err_overflow), 32'd0);
        check_vec("rst_cache_addr", 32'(resp_cache_addr), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // 1: cold read miss, refill of index 2
        wb0 = wr_pulses;
        run_access(16'h0023, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t1_hit", 32'(hit), 32'd0);
        check_vec("t1_cache_addr", 32'(caddr), 32'd35);
        check_vec("t1_wb_seen", 32'(wb_seen), 32'd0);
        check_vec("t1_rd_addr", 32'(rf_addr), 32'h100);
        check_vec("t1_rd_len", 32'(rf_len), 32'd16);
        check_vec("t1_rd_req_drop", 32'(rd_drop), 32'd0);
        check_vec("t1_wr_pulses", 32'(wr_pulses - wb0), 32'd16);
        for (int k = 0; k < DEPTH; k++)
            check_vec($sformatf("t1_wr_addr_%0d", k), 32'(wr_log[wb0 + k]), 32'(32 + k));
        check_vec("t1_wr_data_first", 32'(wr_dlog[wb0]), 32'h1000);
        check_vec("t1_wr_data_last", 32'(wr_dlog[wb0 + 15]), 32'h100F);

        // 2: read hit in the same line
        wb0 = wr_pulses;
        run_access(16'h002A, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t2_hit", 32'(hit), 32'd1);
        check_vec("t2_latency", 32'(lat), 32'd1);
        check_vec("t2_cache_addr", 32'(caddr), 32'd42);
        check_vec("t2_no_burst", 32'({wb_seen, rf_seen}), 32'd0);
        check_vec("t2_no_wr", 32'(wr_pulses - wb0), 32'd0);

        // 3a: write hit marks line dirty
        run_access(16'h0025, 1'b1, 16, -1, hit, lat, caddr, ab);
        check_vec("t3a_hit", 32'(hit), 32'd1);
        check_vec("t3a_latency", 32'(lat), 32'd1);
        check_vec("t3a_cache_addr", 32'(caddr), 32'd37);

        // 3b: conflicting read forces write-back then refill
        rb0 = rd_pulses;
        run_access(16'h0065, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t3b_hit", 32'(hit), 32'd0);
        check_vec("t3b_wb_seen", 32'(wb_seen), 32'd1);
        check_vec("t3b_wb_addr", 32'(wb_addr), 32'h100);
        check_vec("t3b_wb_len", 32'(wb_len), 32'd16);
        check_vec("t3b_wr_req_drop", 32'(wr_drop), 32'd0);
        check_vec("t3b_rd_pulses", 32'(rd_pulses - rb0), 32'd16);
        for (int k = 0; k < DEPTH; k++)
            check_vec($sformatf("t3b_rd_addr_%0d", k), 32'(rd_log[rb0 + k]), 32'(32 + k));
        check_vec("t3b_rf_addr", 32'(rf_addr), 32'h300);
        check_vec("t3b_cache_addr", 32'(caddr), 32'd37);
`ifdef DC_STATS_EN
        check_vec("stats_hit_cnt", 32'(hit_cnt), 32'd2);
        check_vec("stats_miss_cnt", 32'(miss_cnt), 32'd2);
`endif

        // 4: refill with 18 beats overflows the line
        wb0 = wr_pulses;
        run_access(16'h0003, 1'b0, 18, -1, hit, lat, caddr, ab);
        check_vec("t4_hit", 32'(hit), 32'd0);
        check_vec("t4_rf_addr", 32'(rf_addr), 32'h0);
        check_vec("t4_wr_pulses", 32'(wr_pulses - wb0), 32'd16);
        check_vec("t4_err", 32'(err_overflow), 32'd1);
        run_access(16'h0008, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t4_rehit", 32'(hit), 32'd1);
        check_vec("t4_cache_addr", 32'(caddr), 32'd8);
        check_vec("t4_err_sticky", 32'(err_overflow), 32'd1);

        // 5: reset during the 5th refill beat
        run_access(16'h0023, 1'b0, 16, 4, hit, lat, caddr, ab);
        check_vec("t5_aborted", 32'(ab), 32'd1);
        #1;
        check_vec("t5_req_ready", 32'(req_ready), 32'd1);
        check_vec("t5_rd_req", 32'(rd_burst_req), 32'd0);
        check_vec("t5_rd_addr", 32'(rd_burst_addr), 32'd0);
        check_vec("t5_resp_valid", 32'(resp_valid), 32'd0);
        check_vec("t5_ca_wr_en", 32'(ca_wr_en), 32'd0);
        check_vec("t5_err", 32'(err_overflow), 32'd0);
        check_vec("t5_cache_addr", 32'(resp_cache_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_access(16'h0023, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t5_remiss", 32'(hit), 32'd0);
        check_vec("t5_rf_seen", 32'(rf_seen), 32'd1);
        check_vec("t5_rf_addr", 32'(rf_addr), 32'h100);
        check_vec("t5_wb_seen", 32'(wb_seen), 32'd0);
        check_vec("t5_cache_addr2", 32'(caddr), 32'd35);
        run_access(16'h0008, 1'b0, 16, -1, hit, lat, caddr, ab);
        check_vec("t5_invalidated", 32'(hit), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
